// File: rtl/edge_detect_prescaler_if.sv
// Bundle between the external-clock front end and its consumer.
// The timer side drives the controls and observes pulses and the count.
interface edge_detect_prescaler_if #(
    parameter int PRESCALER_BIT = 32
);
    logic                     async_sig;
    logic                     edge_mode;
    logic [PRESCALER_BIT-1:0] prescaler;
    logic                     rise_o;
    logic                     fall_o;
    logic                     active_strobe_o;
    logic [PRESCALER_BIT-1:0] cnt;
    logic                     strobe;
    logic                     clk_pulse;

    modport master (
        output async_sig,
        output edge_mode,
        output prescaler,
        input  rise_o,
        input  fall_o,
        input  active_strobe_o,
        input  cnt,
        input  strobe,
        input  clk_pulse
    );

    modport slave (
        input  async_sig,
        input  edge_mode,
        input  prescaler,
        output rise_o,
        output fall_o,
        output active_strobe_o,
        output cnt,
        output strobe,
        output clk_pulse
    );
endinterface

// File: rtl/edge_detect_prescaler.sv
// Synchronizing edge detector feeding a wrap-at-zero prescaler.
// Emits one strobe per (prescaler+1) selected edges of async_sig.
module edge_detect_prescaler #(
    parameter int PRESCALER_BIT = 32
) (
    input logic                    clk_i,
    input logic                    rst_i,
    edge_detect_prescaler_if.slave bus
);
    logic                     s1;
    logic                     s2;
    logic                     s3;
    logic                     rise;
    logic                     fall;
    logic                     active;
    logic [PRESCALER_BIT-1:0] cnt_q;
    logic                     strobe_q;
    logic                     strobe_past;

    // s1/s2 filter metastability; s3 only provides the previous level.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.async_sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise   = s2 & ~s3;
    assign fall   = ~s2 & s3;
    assign active = bus.edge_mode ? fall : rise;

    // >= lets a lowered prescaler wrap on the next edge and
    // keeps an all-ones prescaler from overflowing the counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else if (active) begin
            if (cnt_q >= bus.prescaler) begin
                cnt_q    <= '0;
                strobe_q <= 1'b1;
            end else begin
                cnt_q    <= cnt_q + PRESCALER_BIT'(1);
                strobe_q <= 1'b0;
            end
        end else begin
            strobe_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            strobe_past <= 1'b0;
        end else begin
            strobe_past <= strobe_q;
        end
    end

    assign bus.rise_o          = rise;
    assign bus.fall_o          = fall;
    assign bus.active_strobe_o = active;
    assign bus.cnt             = cnt_q;
    assign bus.strobe          = strobe_q;
    assign bus.clk_pulse       = strobe_q & ~strobe_past;
endmodule

// File: tb/tb_edge_detect_prescaler.sv
// Self-checking bench: vector table, directed corner cases,
// and randomized traffic against a sample-history reference model.
module tb_edge_detect_prescaler;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    edge_detect_prescaler_if #(.PRESCALER_BIT(W)) bus ();

    edge_detect_prescaler #(.PRESCALER_BIT(W)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic         a;
        logic         em;
        logic [W-1:0] ps;
        logic         rise;
        logic         fall;
        logic [W-1:0] cnt;
        logic         strobe;
    } vec_t;

    int passed = 0;
    int total  = 0;

    // last three sampled async_sig levels, oldest first
    logic         hist[$];
    logic [W-1:0] m_cnt;
    logic         m_str;
    logic         m_sp;

    function automatic logic m_rise();
        return hist[1] & ~hist[0];
    endfunction

    function automatic logic m_fall();
        return ~hist[1] & hist[0];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        hist = '{1'b0, 1'b0, 1'b0};
        m_cnt = '0;
        m_str = 1'b0;
        m_sp = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic act;
        act = bus.edge_mode ? m_fall() : m_rise();
        check({tag, ".rise"}, bus.rise_o, m_rise());
        check({tag, ".fall"}, bus.fall_o, m_fall());
        check({tag, ".active"}, bus.active_strobe_o, act);
        check({tag, ".cnt"}, bus.cnt, m_cnt);
        check({tag, ".strobe"}, bus.strobe, m_str);
        check({tag, ".clk_pulse"}, bus.clk_pulse, m_str & ~m_sp);
    endtask

    // drive inputs, take one clock edge, advance the model, settle 1 step
    task automatic tick(input logic a, input logic em,
                        input logic [W-1:0] ps, input bit chk,
                        input string tag);
        logic counted;
        bus.async_sig = a;
        bus.edge_mode = em;
        bus.prescaler = ps;
        @(posedge clk);
        if (rst_i) begin
            counted = em ? m_fall() : m_rise();
            m_sp = m_str;
            m_str = 1'b0;
            if (counted) begin
                if (m_cnt >= ps) begin
                    m_cnt = '0;
                    m_str = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            hist.push_back(a);
            void'(hist.pop_front());
        end
        #1;
        if (chk) check_model(tag);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        model_reset();
        repeat (3) tick(1'b0, 1'b0, '0, 1'b0, "rst");
        rst_i = 1'b1;
    endtask

    vec_t tbl[16];
    int   n_str;
    int   n_cp;
    int   n_rise;
    int   budget;
    logic a_r;
    logic em_r;
    logic [W-1:0] ps_r;
    int   hold;

    initial begin
        tbl[0]  = '{1, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 1, 0, 1, 1, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 1, 0};
        tbl[6]  = '{1, 0, 1, 1, 0, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 1, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 0, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 1, 0, 0};
        tbl[14] = '{0, 1, 0, 0, 0, 0, 1};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 0};

        // reset held with async_sig toggling: everything stays zero
        rst_i = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick(i[1], 1'b0, '0, 1'b0, "");
            check("rst_hold.cnt", bus.cnt, '0);
            check("rst_hold.pulses",
                  {bus.strobe, bus.clk_pulse, bus.rise_o, bus.fall_o}, '0);
        end
        bus.async_sig = 1'b0;
        rst_i = 1'b1;

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].a, tbl[i].em, tbl[i].ps, 1'b0, "");
            check($sformatf("vec%0d.rise", i), bus.rise_o, tbl[i].rise);
            check($sformatf("vec%0d.fall", i), bus.fall_o, tbl[i].fall);
            check($sformatf("vec%0d.cnt", i), bus.cnt, tbl[i].cnt);
            check($sformatf("vec%0d.strobe", i), bus.strobe, tbl[i].strobe);
            check($sformatf("vec%0d.clk_pulse", i), bus.clk_pulse,
                  tbl[i].strobe);
            check($sformatf("vec%0d.active", i), bus.active_strobe_o,
                  tbl[i].em ? tbl[i].fall : tbl[i].rise);
        end

        // latency: sampled at E1, pulse after E2 only
        do_reset();
        tick(1'b0, 1'b0, '0, 1'b0, "");
        tick(1'b1, 1'b0, '0, 1'b0, "");
        check("lat.rise_E1", bus.rise_o, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0, "");
        check("lat.rise_E2", bus.rise_o, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b0, "");
        check("lat.rise_E3", bus.rise_o, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, "");
        check("lat.fall_E1", bus.fall_o, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, "");
        check("lat.fall_E2", bus.fall_o, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b0, "");
        check("lat.fall_E3", bus.fall_o, 1'b0);

        // rising mode, prescaler 3, 12 rises of period 10
        do_reset();
        n_str = 0;
        for (int i = 0; i < 125; i++) begin
            tick((i % 10) >= 5 && i < 120, 1'b0, 3, 1'b1, "rise3");
            if (bus.strobe) n_str++;
        end
        check("rise3.strobes", n_str, 3);

        // falling mode, prescaler 0, 5 falls
        do_reset();
        n_str = 0;
        n_cp = 0;
        for (int i = 0; i < 58; i++) begin
            tick((i % 10) < 5 || i >= 50, 1'b1, 0, 1'b1, "fall0");
            if (bus.strobe) n_str++;
            if (bus.clk_pulse) n_cp++;
        end
        check("fall0.strobes", n_str, 5);
        check("fall0.clk_pulses", n_cp, 5);

        // prescaler lowered below the running count
        do_reset();
        budget = 0;
        while (m_cnt != 7 && budget < 200) begin
            tick((budget % 6) >= 3, 1'b0, 10, 1'b1, "pchg");
            budget++;
        end
        check("pchg.cnt7", bus.cnt, 7);
        n_rise = 0;
        budget = 0;
        while (!bus.strobe && budget < 30) begin
            tick((budget % 6) >= 3, 1'b0, 4, 1'b1, "pchg");
            if (bus.rise_o) n_rise++;
            budget++;
        end
        check("pchg.strobe", bus.strobe, 1'b1);
        check("pchg.cnt0", bus.cnt, '0);
        check("pchg.edges", n_rise, 1);

        // asynchronous reset between clock edges
        do_reset();
        budget = 0;
        while (m_cnt != 5 && budget < 200) begin
            tick((budget % 4) >= 2, 1'b0, 10, 1'b1, "mrst");
            budget++;
        end
        check("mrst.cnt5", bus.cnt, 5);
        #2;
        rst_i = 1'b0;
        #1;
        check("mrst.cnt", bus.cnt, '0);
        check("mrst.strobe", bus.strobe, 1'b0);
        check("mrst.pulses", {bus.rise_o, bus.fall_o, bus.clk_pulse}, '0);
        do_reset();

        // randomized traffic
        a_r = 1'b0;
        em_r = 1'b0;
        ps_r = 2;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                a_r = ~a_r;
                hold = $urandom_range(2, 6);
            end
            hold--;
            if ($urandom_range(0, 49) == 0) em_r = ~em_r;
            if ($urandom_range(0, 79) == 0)
                ps_r = ($urandom_range(0, 9) == 0) ? '1 : W'($urandom_range(0, 5));
            tick(a_r, em_r, ps_r, 1'b1, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/edge_detect_prescaler.md
# edge_detect_prescaler

Counts edges of an asynchronous external clock and emits one strobe per programmable number of counted edges. It combines a synchronizing edge detector (rising/falling selectable) with a prescaler counter that wraps at zero. It sits at the front of the timer, where its strobe advances the main timer counter in external-clock mode.

## Interface
- PRESCALER_BIT, 32, width of the prescaler value and prescaler counter
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- async_sig  in  1  external clock, asynchronous to clk_i
- edge_mode  in  1  0 = count rising edges, 1 = count falling edges
- prescaler  in  PRESCALER_BIT  divide value; one strobe per (prescaler+1) counted edges
- rise_o  out  1  one-cycle pulse per synchronized 0->1 transition of async_sig
- fall_o  out  1  one-cycle pulse per synchronized 1->0 transition of async_sig
- active_strobe_o  out  1  rise_o when edge_mode=0, fall_o when edge_mode=1
- cnt  out  PRESCALER_BIT  current prescaler count
- strobe  out  1  registered one-cycle pulse on prescaler wrap
- clk_pulse  out  1  rising edge of strobe (strobe & ~previous strobe)

## Operation
- Synchronizer: three flops s1<=async_sig, s2<=s1, s3<=s2; s1 and s2 form the metastability filter.
- rise_o = s2 & ~s3; fall_o = ~s2 & s3; both combinational from flops, and they are mutually exclusive.
- active_strobe_o = edge_mode ? fall_o : rise_o. This is combinational, so changing edge_mode takes effect immediately.
- Prescaler counter, updated on each clk_i edge:
  - if active_strobe_o=1 and cnt >= prescaler: cnt<=0, strobe<=1
  - if active_strobe_o=1 and cnt < prescaler: cnt<=cnt+1, strobe<=0
  - if active_strobe_o=0: cnt holds, strobe<=0
- The ">=" compare ensures that when prescaler is lowered below the current cnt, the next counted edge wraps cnt to 0 and strobes.
- prescaler=0 gives one strobe per counted edge. prescaler=all-ones is legal and gives a divide of 2^PRESCALER_BIT with no overflow, because the compare wraps cnt before it can overflow.
- strobe_past<=strobe each cycle; clk_pulse = strobe & ~strobe_past.
- Reset (rst_i=0, asynchronous): s1..s3, cnt, strobe and strobe_past go to 0. All outputs are then 0, except active_strobe_o/rise_o/fall_o, which follow the zeroed flops and are therefore also 0.
- If async_sig is high at reset release, a rise is detected after 2 cycles. This is accepted behaviour.

## Timing
- async_sig sampled high at edge E1 (previously low): s1=1 after E1, s2=1 after E2, rise_o=1 between E2 and E3, low after E3. Edge-to-pulse latency is 2 clk_i cycles.
- Falling edges have the same latency on fall_o.
- Each rise_o/fall_o pulse lasts exactly one clk_i cycle.
- strobe rises at the edge that samples the wrapping active_strobe_o, so it is high the cycle after active_strobe_o, for exactly one cycle.
- clk_pulse is coincident with strobe (same cycle, combinational).
- Pulses on async_sig shorter than one clk_i period may be missed. async_sig must hold each level at least 2 clk_i periods to be counted reliably.
- Minimum spacing between counted edges is 2 cycles, so strobe is never high two cycles in a row.

## Test plan
- Reset: hold rst_i=0 with async_sig toggling -> cnt=0, strobe=0, clk_pulse=0, rise_o=fall_o=0 throughout. Release -> normal counting starts.
- Rising mode, prescaler=3, 12 rising edges of async_sig (period 10 clk) -> cnt sequence 1,2,3,0 repeating; 3 strobe pulses, each 1 cycle, each 3 cycles after the corresponding async_sig rise; fall_o pulses do not change cnt.
- Falling mode, prescaler=0, 5 falling edges -> 5 strobe/clk_pulse pulses, cnt stays 0, rise_o still pulses but is ignored.
- Latency check: async_sig 0->1 just before edge E1 -> rise_o high exactly in cycle E2-E3; async_sig 1->0 -> fall_o has the same latency.
- Prescaler change: prescaler=10, count to cnt=7, set prescaler=4 -> next rising edge gives cnt=0 and strobe=1.
- Reset mid-count: cnt=5, strobe pending, assert rst_i asynchronously between clock edges -> cnt=0 and strobe=0 immediately, without waiting for a clock edge.
